fcvt_seq: RTL
=============

Name: fcvt_seq

Overview:
- Multi-cycle sequencer for the FPU integer-to-single conversion path (FCVT.S.W / FCVT.S.WU).
- Accepts one conversion per valid/ready handshake and normalizes the magnitude iteratively.
- Applies the RISC-V rounding mode in a dedicated cycle, then holds the result until the writeback stage takes it.
- Sits between the FP issue stage and FP writeback.

Parameters:
- NORM_STEP, 1, maximum left-shift applied per normalization cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-high reset. The port keeps the codebase's name; asserted means reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- rs1  input  32  integer operand.
- is_unsigned  input  1  1 = FCVT.S.WU, 0 = FCVT.S.W.
- rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  32  IEEE-754 single-precision result.
- fflags  output  5  exception flags; only bit 0 (NX) is ever set.

Behaviour:
- States: IDLE, NORM, ROUND, DONE.
- Reset: state goes to IDLE; out_valid=0, out=0, fflags=0. Internal mag, exp, sign and rm are cleared.
  - in_ready=0 while resetn is asserted.
  - Reset mid-operation abandons the conversion with no output.
- in_ready = (state==IDLE) && !resetn. A transfer occurs on any edge where in_valid && in_ready.
- Accept (IDLE):
  - Latch sign = !is_unsigned & rs1[31].
  - mag = sign ? (~rs1+1) : rs1, 32-bit unsigned. 0x80000000 signed gives mag 0x80000000.
  - exp = 8'd158, i.e. 127+31, held in a 9-bit register. Latch rm.
  - If mag==0: go directly to DONE with out=32'h0 (+0, never -0) and fflags=0.
  - Otherwise go to NORM.
- NORM (one decision per cycle):
  - If mag[31]==1: go to ROUND with no shift.
  - Else if the top NORM_STEP bits of mag are all 0 and NORM_STEP>1: mag <<= NORM_STEP, exp -= NORM_STEP.
  - Else: mag <<= 1, exp -= 1.
- ROUND (one cycle):
  - mant = mag[30:8], g = mag[7], s = |mag[6:0], lsb = mag[8].
  - Increment condition by mode:
    - RNE: g & (s | lsb)
    - RTZ: 0
    - RDN: sign & (g|s)
    - RUP: !sign & (g|s)
    - RMM: g
  - If incrementing and mant==23'h7FFFFF: mant=0, exp+=1. Max exp is 159; overflow is impossible.
  - Register out = {sign, exp[7:0], mant} and NX = g|s. Go to DONE.
- DONE:
  - out_valid=1; out and fflags are stable.
  - When out_ready=1: on that edge out_valid goes to 0 and state goes to IDLE.
  - out and fflags keep their last value after the handshake.
  - No new request is accepted in the same cycle as the output handshake. in_ready rises the following cycle.
- Latency, counted in edges from the accept edge to out_valid high:
  - zero operand: 1
  - otherwise: 2 + (number of NORM cycles)
  - Example, NORM_STEP=1: 0x80000000 takes 3; rs1=1 takes 34.
- Inputs are sampled only on the accept edge. rs1, rm and is_unsigned may change freely afterwards.
- fflags bits [4:1] are always 0. fflags is updated only when out is updated.

Optional Feature:
- Macro FCVT_SEQ_FLAGS_EN.
- Defined: fflags[0] carries NX as computed in ROUND. The zero operand gives NX=0.
- Undefined: fflags is constant 5'b0 and the NX register is not built. Rounding and out are unchanged.

Test Plan:
- Zero: rs1=0x00000000, is_unsigned=0, rm=RNE → out=0x00000000, fflags=0, out_valid one edge after accept.
- Basic signed, NORM_STEP=1: rs1=1 → out=0x3F800000, NX=0, out_valid 34 edges after accept. rs1=0x80000000 signed → 0xCF000000, latency 3.
- Sign/unsigned, RNE: rs1=0xFFFFFFFF, signed → 0xBF800000, NX=0. Same operand, unsigned → 0x4F800000, NX=1 (mantissa carry into exponent).
- Rounding modes: rs1=0x01000001 (16777217) gives:
  - RNE → 0x4B800000, NX=1
  - RUP → 0x4B800001
  - RTZ → 0x4B800000
  - RMM → 0x4B800001
  - negated operand with RDN → 0xCB800001
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out and out_valid stable, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → out_valid=0 next edge, in_ready=1 one cycle later.
- Reset mid-operation: assert resetn during NORM (rs1=1) → out_valid=0 and out=0 immediately (asynchronous). After release, in_ready=1 and the next request rs1=2 gives 0x40000000.

Source files
------------

// File: rtl/fcvt_seq.sv
// Multi-cycle FCVT.S.W / FCVT.S.WU sequencer: iterative normalise, one rounding cycle, held result.
// Optional FCVT_SEQ_FLAGS_EN builds the NX flag register; otherwise fflags is tied to zero.
module fcvt_seq #(
    parameter int unsigned NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [4:0]  fflags
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [8:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] out_q, out_d;

    logic        accept;
    logic        in_sign;
    logic [31:0] in_mag;
    logic        top_zero;
    logic [22:0] mant, mant_rnd;
    logic        g, s, lsb, inc, carry;
    logic [8:0]  exp_rnd;
    logic        unused_exp_msb;

    assign accept   = in_valid && in_ready;
    assign in_sign  = !is_unsigned && rs1[31];
    assign in_mag   = in_sign ? (~rs1 + 32'd1) : rs1;
    assign top_zero = (mag_q[31 -: NORM_STEP] == '0);

    assign mant = mag_q[30:8];
    assign g    = mag_q[7];
    assign s    = |mag_q[6:0];
    assign lsb  = mag_q[8];

    always_comb begin
        unique case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q && (g || s);
            3'b011:  inc = !sign_q && (g || s);
            3'b100:  inc = g;
            default: inc = g && (s || lsb);
        endcase
    end

    // Mantissa carry-out bumps the exponent; exp never exceeds 159 so bit 8 stays clear.
    assign {carry, mant_rnd} = {1'b0, mant} + {23'd0, inc};
    assign exp_rnd           = exp_q + {8'd0, carry};
    assign unused_exp_msb    = exp_rnd[8];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (in_mag == 32'd0) ? StDone : StNorm;
            StNorm:  if (mag_q[31]) state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !resetn;
        out_valid = (state_q == StDone);
        out       = out_q;
    end

    always_comb begin
        mag_d  = mag_q;
        exp_d  = exp_q;
        sign_d = sign_q;
        rm_d   = rm_q;
        out_d  = out_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d = in_sign;
                    mag_d  = in_mag;
                    exp_d  = 9'd158;
                    rm_d   = rm;
                    if (in_mag == 32'd0) out_d = 32'd0;
                end
            end
            StNorm: begin
                if (!mag_q[31]) begin
                    if (NORM_STEP > 1 && top_zero) begin
                        mag_d = mag_q << NORM_STEP;
                        exp_d = exp_q - 9'(NORM_STEP);
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - 9'd1;
                    end
                end
            end
            StRound: out_d = {sign_q, exp_rnd[7:0], mant_rnd};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            mag_q  <= 32'd0;
            exp_q  <= 9'd0;
            sign_q <= 1'b0;
            rm_q   <= 3'd0;
            out_q  <= 32'd0;
        end else begin
            mag_q  <= mag_d;
            exp_q  <= exp_d;
            sign_q <= sign_d;
            rm_q   <= rm_d;
            out_q  <= out_d;
        end
    end

`ifdef FCVT_SEQ_FLAGS_EN
    logic nx_q, nx_d;

    always_comb begin
        nx_d = nx_q;
        if (state_q == StIdle && accept && in_mag == 32'd0) nx_d = 1'b0;
        if (state_q == StRound) nx_d = g || s;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            nx_q <= 1'b0;
        end else begin
            nx_q <= nx_d;
        end
    end

    assign fflags = {4'b0000, nx_q};
`else
    assign fflags = 5'b00000;
`endif

endmodule
